// File: rtl/line_buffer_3x3_6.sv
// Purpose: raster-order 6-bit pixel stream in, sliding 3x3 window out (two line buffers + window register).
// Latency: a window appears the cycle after the pixel that completes it is accepted; 1 pixel/clock sustained.
// Backpressure: in_ready = !out_valid | out_ready, so a held window stalls input with no skid buffering.
module line_buffer_3x3_6 #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] in_pixel,
    output logic       in_ready,
    output logic [5:0] win_0,
    output logic [5:0] win_1,
    output logic [5:0] win_2,
    output logic [5:0] win_3,
    output logic [5:0] win_4,
    output logic [5:0] win_5,
    output logic [5:0] win_6,
    output logic [5:0] win_7,
    output logic [5:0] win_8,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // lb_top holds row r-2, lb_mid holds row r-1, both indexed by column
    logic [5:0] lb_top [IMG_W];
    logic [5:0] lb_mid [IMG_W];

    // window register, row-major: index 3*wr + wc
    logic [5:0] win [9];

    logic       in_xfer;
    logic       out_xfer;
    logic       col_last;
    logic       row_last;
    logic       win_hit;
    logic [5:0] top_pix;
    logic [5:0] mid_pix;

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    // only pixels with two rows and two columns of history complete a real window,
    // which also hides stale line-buffer data left over from the previous frame
    assign win_hit  = (row >= RW'(2)) && (col >= CW'(2));
    assign top_pix  = lb_top[col];
    assign mid_pix  = lb_mid[col];

    // raster position counters and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= in_xfer && col_last && row_last;
            if (in_xfer) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // line buffers: the column slot ages one row per accepted pixel; contents need no reset
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            lb_top[col] <= mid_pix;
            lb_mid[col] <= in_pixel;
        end
    end

    // window shifts left and takes the new column {r-2, r-1, incoming} on each accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else if (in_xfer) begin
            for (int r = 0; r < 3; r++) begin
                win[3*r]     <= win[3*r + 1];
                win[3*r + 1] <= win[3*r + 2];
            end
            win[2] <= top_pix;
            win[5] <= mid_pix;
            win[8] <= in_pixel;
        end
    end

    // window valid: set by a window-completing pixel, cleared once consumed otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (in_xfer && win_hit) begin
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    assign win_0 = win[0];
    assign win_1 = win[1];
    assign win_2 = win[2];
    assign win_3 = win[3];
    assign win_4 = win[4];
    assign win_5 = win[5];
    assign win_6 = win[6];
    assign win_7 = win[7];
    assign win_8 = win[8];

endmodule

// File: tb/tb_line_buffer_3x3_6.sv
// Purpose: scoreboard bench for line_buffer_3x3_6 across 4x4, 8x8 and 5x6 instances.
// Latency: expects each window the cycle after its completing pixel when out_ready is held high.
// Backpressure: exercises held windows, a fixed 5-cycle stall and random out_ready.
module tb_line_buffer_3x3_6;
    typedef logic [8:0][5:0] win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n;
    int         sel;            // 0: 4x4 instance, 1: 8x8, 2: 5x6
    logic       in_valid_d;
    logic [5:0] in_pixel_d;
    logic       out_ready_d;

    wire iv4  = in_valid_d && (sel == 0);
    wire iv8  = in_valid_d && (sel == 1);
    wire iv56 = in_valid_d && (sel == 2);

    wire       ir4, ov4, fd4, ir8, ov8, fd8, ir56, ov56, fd56;
    wire [8:0][5:0] w4, w8, w56;

    line_buffer_3x3_6 #(.IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_pixel(in_pixel_d), .in_ready(ir4),
        .win_0(w4[0]), .win_1(w4[1]), .win_2(w4[2]), .win_3(w4[3]), .win_4(w4[4]),
        .win_5(w4[5]), .win_6(w4[6]), .win_7(w4[7]), .win_8(w4[8]),
        .out_valid(ov4), .out_ready(out_ready_d), .frame_done(fd4));

    line_buffer_3x3_6 #(.IMG_W(8), .IMG_H(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_pixel(in_pixel_d), .in_ready(ir8),
        .win_0(w8[0]), .win_1(w8[1]), .win_2(w8[2]), .win_3(w8[3]), .win_4(w8[4]),
        .win_5(w8[5]), .win_6(w8[6]), .win_7(w8[7]), .win_8(w8[8]),
        .out_valid(ov8), .out_ready(out_ready_d), .frame_done(fd8));

    line_buffer_3x3_6 #(.IMG_W(5), .IMG_H(6)) u_dut56 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv56), .in_pixel(in_pixel_d), .in_ready(ir56),
        .win_0(w56[0]), .win_1(w56[1]), .win_2(w56[2]), .win_3(w56[3]), .win_4(w56[4]),
        .win_5(w56[5]), .win_6(w56[6]), .win_7(w56[7]), .win_8(w56[8]),
        .out_valid(ov56), .out_ready(out_ready_d), .frame_done(fd56));

    // outputs of whichever instance is active
    wire       m_ir  = (sel == 0) ? ir4 : (sel == 1) ? ir8 : ir56;
    wire       m_ov  = (sel == 0) ? ov4 : (sel == 1) ? ov8 : ov56;
    wire       m_fd  = (sel == 0) ? fd4 : (sel == 1) ? fd8 : fd56;
    wire win_t m_win = (sel == 0) ? w4  : (sel == 1) ? w8  : w56;

    // reference model: current frame image plus expected-response queues
    int         img_w, img_h, pos;
    logic [5:0] img [0:63];
    win_t       exp_win_q [$];
    int         exp_cyc_q [$];
    int         fd_q [$];

    int   n_cmp = 0, n_fail = 0;
    int   got_win = 0, fd_cnt = 0;
    bit   chk_timing = 1'b0;
    bit   rnd_in = 1'b0, rnd_out = 1'b0;
    bit   stall_arm = 1'b0;
    int   stall_cnt = 0;
    bit   held = 1'b0;
    win_t held_win;
    win_t ew;
    int   ec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // the pixel just accepted sits at (pos / W, pos % W); its window is the 3x3 block ending there
    task automatic model_accept(input logic [5:0] p);
        int   r, c;
        win_t e;
        r = pos / img_w;
        c = pos % img_w;
        img[pos] = p;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 9; i++) begin
                e[i] = img[(r - 2 + i / 3) * img_w + (c - 2 + i % 3)];
            end
            exp_win_q.push_back(e);
            exp_cyc_q.push_back(cyc + 1);
        end
        pos++;
        if (pos == img_w * img_h) begin
            pos = 0;
            fd_q.push_back(cyc + 1);
        end
    endtask

    task automatic send(input logic [5:0] p);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        if (rnd_in) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid_d = 1'b1;
        in_pixel_d = p;
        while (!ok && t < 200) begin
            @(negedge clk);
            if (m_ir) ok = 1'b1;
            else t++;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready, expected acceptance of pixel 0x%0h", p);
        end else begin
            model_accept(p);
        end
        @(posedge clk);
        #1;
        in_valid_d = 1'b0;
    endtask

    task automatic select(input int s, input int w, input int h);
        sel   = s;
        img_w = w;
        img_h = h;
        pos   = 0;
    endtask

    task automatic end_scenario(input string name, input int exp_w, input int exp_fd);
        int t;
        t = 0;
        while ((exp_win_q.size() != 0 || m_ov) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({name, "_window_count"}, 64'(got_win), 64'(exp_w));
        check({name, "_frame_done_count"}, 64'(fd_cnt), 64'(exp_fd));
        check({name, "_pending_windows"}, 64'(exp_win_q.size()), 64'd0);
        check({name, "_pending_frame_done"}, 64'(fd_q.size()), 64'd0);
        got_win = 0;
        fd_cnt  = 0;
        exp_win_q.delete();
        exp_cyc_q.delete();
        fd_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_win"}, 64'(m_win), 64'd0);
        check({name, "_out_valid"}, 64'(m_ov), 64'd0);
        check({name, "_frame_done"}, 64'(m_fd), 64'd0);
        check({name, "_in_ready"}, 64'(m_ir), 64'd1);
    endtask

    // monitor: handshake rule, hold stability, window and frame_done scoreboards
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            check("in_ready_rule", 64'(m_ir), 64'(!m_ov || out_ready_d));
            if (held) check("hold_stable", 64'({m_ov, m_win}), 64'({1'b1, held_win}));
            if (m_ov && out_ready_d) begin
                if (exp_win_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_window: got 0x%0h, expected no window", m_win);
                end else begin
                    ew = exp_win_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("window", 64'(m_win), 64'(ew));
                    if (chk_timing) check("window_cycle", 64'(cyc), 64'(ec));
                end
                got_win++;
            end
            held     = m_ov && !out_ready_d;
            held_win = m_win;
            if (m_fd) begin
                if (fd_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    check("frame_done_cycle", 64'(cyc), 64'(fd_q.pop_front()));
                end
                fd_cnt++;
            end
        end
    end

    // downstream ready: optional one-shot 5-cycle stall at the first window, else random or high
    initial begin
        out_ready_d = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                out_ready_d = 1'b0;
                stall_cnt--;
            end else if (stall_arm && m_ov) begin
                out_ready_d = 1'b0;
                stall_cnt   = 4;
                stall_arm   = 1'b0;
            end else begin
                out_ready_d = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by t=%0t, expected completion", $time);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid_d = 1'b0;
        in_pixel_d = '0;
        select(0, 4, 4);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: 4x4 ramp, always ready; first window 0,1,2,4,5,6,8,9,10 one cycle after pixel 10
        chk_timing = 1'b1;
        for (int k = 0; k < 16; k++) send(6'(k));
        end_scenario("s1", 4, 1);

        // 2: same ramp with a 5-cycle stall at the first window
        chk_timing = 1'b0;
        stall_arm  = 1'b1;
        for (int k = 0; k < 16; k++) send(6'(k));
        end_scenario("s2", 4, 1);

        // 3: two back-to-back frames; 100+k wraps modulo 64 in the 6-bit pixel
        chk_timing = 1'b1;
        for (int k = 0; k < 16; k++) send(6'(k));
        for (int k = 0; k < 16; k++) send(6'(100 + k));
        end_scenario("s3", 8, 2);

        // 4: reset mid-frame after pixel 6, then a clean frame
        for (int k = 0; k < 7; k++) send(6'(k));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("midreset");
        pos = 0;
        exp_win_q.delete();
        exp_cyc_q.delete();
        fd_q.delete();
        got_win = 0;
        fd_cnt  = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 16; k++) send(6'(k));
        end_scenario("s4", 4, 1);

        // 5: 8x8 continuous stream, random data, one window per cycle within a row
        select(1, 8, 8);
        for (int k = 0; k < 64; k++) send(6'($urandom));
        end_scenario("s5", 36, 1);

        // 6: 5x6 with random in_valid gaps and random out_ready
        select(2, 5, 6);
        chk_timing = 1'b0;
        rnd_in     = 1'b1;
        rnd_out    = 1'b1;
        for (int k = 0; k < 30; k++) send(6'($urandom));
        rnd_out = 1'b0;
        end_scenario("s6", 12, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
